// File: rtl/frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tfmbs_frame_pkg
// Brief    : Shared state encoding and hint-field constants for frame_sequencer.
// Revision : 1.0
// ============================================================================
package tfmbs_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } seq_state_t;

   localparam logic [7:0] KERNEL_TCONV         = 8'h04;
   localparam int         HINT_CONV_STRIDE_LSB = 20;
   localparam int         HINT_KERNEL_MSB      = 7;

   // Column stride multiplier: T-CONV kernels step (conv_m1 + 1) lanes per column.
   function automatic logic [2:0] conv_factor(input logic [7:0] kernel,
                                              input logic [1:0] conv_m1);
      if (kernel == KERNEL_TCONV) begin
         return {1'b0, conv_m1} + 3'd1;
      end
      return 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer_if
// Brief    : Valid/ready address request channel toward the memory read port.
// Revision : 1.0
// ============================================================================
interface frame_sequencer_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_last;
   logic                  req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_last,
      output req_ready
   );

endinterface
`default_nettype wire

// File: rtl/frame_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_addr_gen
// Brief    : Row/column walker holding the latched geometry and request address.
// Revision : 1.0
// ============================================================================
module frame_addr_gen #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DIM_WIDTH    = 16,
   parameter int STRIDE_WIDTH = 8,
   parameter int PITCH_WIDTH  = 24
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic                    load,
   input  wire logic                    advance,
   input  wire logic [ADDR_WIDTH-1:0]   base_addr,
   input  wire logic [DIM_WIDTH-1:0]    cols,
   input  wire logic [DIM_WIDTH-1:0]    rows,
   input  wire logic [STRIDE_WIDTH+1:0] eff_stride,
   input  wire logic [PITCH_WIDTH-1:0]  row_pitch,
   output logic      [ADDR_WIDTH-1:0]   addr,
   output logic                         is_last
);

   logic [DIM_WIDTH-1:0]    r_rows;
   logic [DIM_WIDTH-1:0]    r_cols;
   logic [STRIDE_WIDTH+1:0] r_stride;
   logic [PITCH_WIDTH-1:0]  r_pitch;
   logic [DIM_WIDTH-1:0]    r_row;
   logic [DIM_WIDTH-1:0]    r_col;
   logic [ADDR_WIDTH-1:0]   r_row_base;
   logic [ADDR_WIDTH-1:0]   r_addr;

   logic [ADDR_WIDTH-1:0]   w_stride_ext;
   logic [ADDR_WIDTH-1:0]   w_pitch_ext;
   logic                    w_col_end;
   logic                    w_row_end;

   assign w_stride_ext = {{(ADDR_WIDTH-STRIDE_WIDTH-2){1'b0}}, r_stride};
   assign w_pitch_ext  = {{(ADDR_WIDTH-PITCH_WIDTH){1'b0}}, r_pitch};
   assign w_col_end    = (r_col == r_cols - DIM_WIDTH'(1));
   assign w_row_end    = (r_row == r_rows - DIM_WIDTH'(1));
   assign is_last      = w_col_end && w_row_end;
   assign addr         = r_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rows     <= '0;
         r_cols     <= '0;
         r_stride   <= '0;
         r_pitch    <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
      end else if (load) begin
         r_rows     <= rows;
         r_cols     <= cols;
         r_stride   <= eff_stride;
         r_pitch    <= row_pitch;
         r_row      <= '0;
         r_col      <= '0;
         r_row_base <= base_addr;
         r_addr     <= base_addr;
      end else if (advance) begin
         if (!w_col_end) begin
            r_col  <= r_col + DIM_WIDTH'(1);
            r_addr <= r_addr + w_stride_ext;
         end else begin
            // Next row starts from the row base, not from the last column address.
            r_col      <= '0;
            r_row      <= r_row + DIM_WIDTH'(1);
            r_row_base <= r_row_base + w_pitch_ext;
            r_addr     <= r_row_base + w_pitch_ext;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Brief    : 2-D frame address sequencer with T-CONV stride scaling and abort.
// Revision : 1.0
// ============================================================================
module frame_sequencer
   import tfmbs_frame_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DIM_WIDTH    = 16,
   parameter int STRIDE_WIDTH = 8,
   parameter int PITCH_WIDTH  = 24
) (
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic [ADDR_WIDTH-1:0]   base_addr,
   input  wire logic [DIM_WIDTH-1:0]    frame_cols,
   input  wire logic [DIM_WIDTH-1:0]    frame_rows,
   input  wire logic [STRIDE_WIDTH-1:0] lane_stride,
   input  wire logic [PITCH_WIDTH-1:0]  row_pitch,
   input  wire logic [31:0]             exec_hints,
   input  wire logic                    start,
   input  wire logic                    abort,
   output logic                         busy,
   output logic                         engine_enable,
   frame_sequencer_if.master            req,
   output logic                         done,
   output logic                         aborted,
   output logic                         cfg_err,
   output logic [2*DIM_WIDTH-1:0]       elem_count
);

   seq_state_t r_state;
   seq_state_t w_next_state;

   logic                    r_aborted;
   logic                    r_cfg_err;
   logic [2*DIM_WIDTH-1:0]  r_elem_count;

   logic                    w_load;
   logic                    w_advance;
   logic                    w_hs;
   logic                    w_is_last;
   logic                    w_dims_zero;
   logic [2:0]              w_factor;
   logic [STRIDE_WIDTH+1:0] w_eff_stride;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic                    w_unused_hints;

   assign w_unused_hints = ^{exec_hints[31:HINT_CONV_STRIDE_LSB+2],
                             exec_hints[HINT_CONV_STRIDE_LSB-1:HINT_KERNEL_MSB+1]};

   assign w_factor     = conv_factor(exec_hints[HINT_KERNEL_MSB:0],
                                     exec_hints[HINT_CONV_STRIDE_LSB+1:HINT_CONV_STRIDE_LSB]);
   assign w_eff_stride = {2'b00, lane_stride} * (STRIDE_WIDTH+2)'(w_factor);
   assign w_dims_zero  = (frame_rows == '0) || (frame_cols == '0);

   assign w_load    = (r_state == ST_IDLE) && start;
   assign w_hs      = (r_state == ST_ISSUE) && req.req_ready;
   assign w_advance = w_hs && !w_is_last;

   frame_addr_gen #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DIM_WIDTH    (DIM_WIDTH),
      .STRIDE_WIDTH (STRIDE_WIDTH),
      .PITCH_WIDTH  (PITCH_WIDTH)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (w_load),
      .advance    (w_advance),
      .base_addr  (base_addr),
      .cols       (frame_cols),
      .rows       (frame_rows),
      .eff_stride (w_eff_stride),
      .row_pitch  (row_pitch),
      .addr       (w_addr),
      .is_last    (w_is_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      busy          = 1'b0;
      engine_enable = 1'b0;
      done          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = w_dims_zero ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            busy          = 1'b1;
            engine_enable = 1'b1;
            if ((w_hs && w_is_last) || abort) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            done         = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aborted    <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_elem_count <= '0;
      end else begin
         if (w_load) begin
            r_aborted    <= 1'b0;
            r_cfg_err    <= w_dims_zero;
            r_elem_count <= '0;
         end
         if (w_hs) begin
            r_elem_count <= r_elem_count + (2*DIM_WIDTH)'(1);
         end
         // A final handshake completes the frame normally even if abort coincides.
         if ((r_state == ST_ISSUE) && abort && !(w_hs && w_is_last)) begin
            r_aborted <= 1'b1;
         end
      end
   end

   assign req.req_valid = (r_state == ST_ISSUE);
   assign req.req_addr  = w_addr;
   assign req.req_last  = (r_state == ST_ISSUE) && w_is_last;
   assign aborted       = r_aborted;
   assign cfg_err       = r_cfg_err;
   assign elem_count    = r_elem_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Brief    : Scoreboard bench for frame_sequencer address walks and flags.
// Revision : 1.0
// ============================================================================
module tb_frame_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] base_addr;
   logic [15:0] frame_cols;
   logic [15:0] frame_rows;
   logic [7:0]  lane_stride;
   logic [23:0] row_pitch;
   logic [31:0] exec_hints;
   logic        start;
   logic        abort;
   logic        busy;
   logic        engine_enable;
   logic        done;
   logic        aborted;
   logic        cfg_err;
   logic [31:0] elem_count;

   frame_sequencer_if #(.ADDR_WIDTH(32)) rq ();

   frame_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .base_addr     (base_addr),
      .frame_cols    (frame_cols),
      .frame_rows    (frame_rows),
      .lane_stride   (lane_stride),
      .row_pitch     (row_pitch),
      .exec_hints    (exec_hints),
      .start         (start),
      .abort         (abort),
      .busy          (busy),
      .engine_enable (engine_enable),
      .req           (rq),
      .done          (done),
      .aborted       (aborted),
      .cfg_err       (cfg_err),
      .elem_count    (elem_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Request monitor: pops the scoreboard on each handshake and checks stall hold.
   initial begin
      logic        stall_p;
      logic [31:0] h_addr;
      logic        h_last;
      exp_t        e;
      stall_p = 1'b0;
      h_addr  = '0;
      h_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (rq.req_valid === 1'b1) begin
            if (sb.size() == 0) check("spurious_req", {63'd0, rq.req_valid}, 64'd0);
            if (stall_p) begin
               check("hold_addr", {32'd0, rq.req_addr}, {32'd0, h_addr});
               check("hold_last", {63'd0, rq.req_last}, {63'd0, h_last});
            end
            if (rq.req_ready) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("addr", {32'd0, rq.req_addr}, {32'd0, e.addr});
                  check("last", {63'd0, rq.req_last}, {63'd0, e.last});
               end
               stall_p = 1'b0;
            end else begin
               stall_p = 1'b1;
               h_addr  = rq.req_addr;
               h_last  = rq.req_last;
            end
         end else begin
            stall_p = 1'b0;
         end
      end
   end

   task automatic push_model(input logic [31:0] base, input int rows, input int cols,
                             input int stride, input int pitch, input logic [31:0] hints);
      int          eff;
      logic [31:0] a;
      exp_t        e;
      eff = stride;
      if (hints[7:0] == 8'h04) eff = stride * (int'(hints[21:20]) + 1);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            a      = base + 32'(r) * 32'(pitch) + 32'(c) * 32'(eff);
            e.addr = a;
            e.last = (r == rows - 1) && (c == cols - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_frame(input logic [31:0] base, input int rows, input int cols,
                            input int stride, input int pitch, input logic [31:0] hints,
                            input bit stall, input int abort_at, input bit extra_starts);
      int  n;
      int  cyc;
      int  nhs;
      bit  seen;
      bit  zero;
      bit  exp_abort;
      int  exp_count;
      n         = rows * cols;
      zero      = (rows == 0) || (cols == 0);
      exp_abort = (abort_at != 0) && (abort_at < n);
      exp_count = zero ? 0 : (exp_abort ? abort_at : n);
      if (!zero) push_model(base, rows, cols, stride, pitch, hints);

      base_addr   = base;
      frame_rows  = 16'(rows);
      frame_cols  = 16'(cols);
      lane_stride = 8'(stride);
      row_pitch   = 24'(pitch);
      exec_hints  = hints;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Latched copies only: scramble the live config inputs.
      base_addr   = 32'hDEAD_0000;
      frame_rows  = 16'd9;
      frame_cols  = 16'd7;
      lane_stride = 8'd33;
      row_pitch   = 24'h000777;
      exec_hints  = 32'h0030_0004;
      cyc  = 1;
      nhs  = 0;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            rq.req_ready = stall ? (cyc % 3 == 1) : 1'b1;
            if (rq.req_valid && rq.req_ready) nhs++;
            abort = (abort_at != 0) && (nhs == abort_at) && rq.req_valid && rq.req_ready;
            start = extra_starts && (cyc == 2);
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            cyc++;
         end
      end
      rq.req_ready = 1'b1;
      check("done_seen", {63'd0, seen}, 64'd1);
      if (seen) begin
         if (zero) check("cfg_latency", 64'(cyc + 1), 64'd2);
         else if (!stall && abort_at == 0) check("latency", 64'(cyc + 1), 64'(n + 2));
         check("elem_count", {32'd0, elem_count}, 64'(exp_count));
         check("aborted", {63'd0, aborted}, {63'd0, exp_abort});
         check("cfg_err", {63'd0, cfg_err}, {63'd0, zero});
         check("done_valid", {63'd0, rq.req_valid}, 64'd0);
         check("done_busy", {62'd0, busy, engine_enable}, 64'd0);
      end
      if (exp_abort) sb.delete();
      else check("sb_empty", 64'(sb.size()), 64'd0);
      start = extra_starts;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_pulse", {63'd0, done}, 64'd0);
      if (extra_starts) begin
         @(posedge clk); #1;
         check("done_start_ignored", {63'd0, busy}, 64'd0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      base_addr    = '0;
      frame_cols   = '0;
      frame_rows   = '0;
      lane_stride  = '0;
      row_pitch    = '0;
      exec_hints   = '0;
      start        = 1'b0;
      abort        = 1'b0;
      rq.req_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_outputs", {57'd0, busy, engine_enable, done, aborted, cfg_err,
                            rq.req_valid, rq.req_last}, 64'd0);
      check("rst_addr_cnt", {rq.req_addr, elem_count}, 64'd0);

      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0000_0000, 1'b0, 0, 1'b0);
      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0020_0004, 1'b0, 0, 1'b0);
      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0030_0005, 1'b0, 0, 1'b0);
      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0000_0000, 1'b1, 0, 1'b0);
      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0000_0000, 1'b0, 3, 1'b0);
      run_frame(32'h0000_1000, 2, 3, 4, 'h100, 32'h0000_0000, 1'b0, 6, 1'b0);
      run_frame(32'h0000_1000, 2, 0, 4, 'h100, 32'h0000_0000, 1'b0, 0, 1'b0);

      // Idle reset must clear the sticky cfg_err left by the previous frame.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_cfg_err", {63'd0, cfg_err}, 64'd0);

      run_frame(32'h0000_1000, 0, 5, 4, 'h100, 32'h0000_0000, 1'b0, 0, 1'b0);
      run_frame(32'hFFFF_FFF8, 2, 3, 4, 'h10, 32'h0010_0004, 1'b1, 0, 1'b0);

      // Mid-frame reset.
      push_model(32'h0000_4000, 2, 3, 4, 'h100, 32'h0000_0000);
      base_addr   = 32'h0000_4000;
      frame_rows  = 16'd2;
      frame_cols  = 16'd3;
      lane_stride = 8'd4;
      row_pitch   = 24'h000100;
      exec_hints  = '0;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      check("midrst_outputs", {57'd0, busy, engine_enable, done, aborted, cfg_err,
                               rq.req_valid, rq.req_last}, 64'd0);
      check("midrst_addr_cnt", {rq.req_addr, elem_count}, 64'd0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("midrst_idle", {63'd0, busy}, 64'd0);

      run_frame(32'h0000_2000, 3, 2, 2, 'h40, 32'h0000_0000, 1'b0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
